// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 control slice.
// Holds the FSM state encoding, round/block sizing and W-buffer address width.
package sha512_pkg;

    localparam int SHA512_ROUNDS    = 80;
    localparam int SHA512_BLK_WORDS = 32;
    localparam int SHA512_WADDR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sha512_word_packer.sv
// Packs 32-bit message words into 64-bit W-buffer writes.
// Tracks word count, half flag, held high word and the last-block flag.
module sha512_word_packer
    import sha512_pkg::*;
#(
    parameter int BLK_WORDS = SHA512_BLK_WORDS
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      en,
    input  logic [31:0]               din,
    input  logic                      din_valid,
    input  logic                      last,
    output logic                      din_ready,
    output logic                      load_we,
    output logic [SHA512_WADDR_W-1:0] load_addr,
    output logic [63:0]               load_data,
    output logic                      block_full,
    output logic                      last_flag
);

    localparam int CNT_W = $clog2(BLK_WORDS);

    logic [CNT_W-1:0] word_cnt;
    logic             half;
    logic [31:0]      hi;
    logic             accept;

    assign din_ready  = en;
    assign accept     = en & din_valid;
    assign block_full = accept & (word_cnt == CNT_W'(BLK_WORDS - 1));
    assign load_we    = accept & half;
    assign load_addr  = SHA512_WADDR_W'(word_cnt >> 1);
    assign load_data  = load_we ? {hi, din} : 64'd0;

    // Advance packing state on each accepted word; gaps hold everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_cnt  <= '0;
            half      <= 1'b0;
            hi        <= 32'd0;
            last_flag <= 1'b0;
        end else if (accept) begin
            last_flag <= last;
            if (block_full) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (!half) begin
                hi   <= din;
                half <= 1'b1;
            end else begin
                half <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sha512_round_ctrl.sv
// Top-level SHA-512 control FSM: load, round sequencing, H init/update.
// Optional block counter output enabled by SHA512_CTRL_BLKCNT_EN.
module sha512_round_ctrl
    import sha512_pkg::*;
#(
    parameter int ROUNDS    = SHA512_ROUNDS,
    parameter int BLK_WORDS = SHA512_BLK_WORDS
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [31:0]               i_din,
    input  logic                      i_din_valid,
    input  logic                      i_last,
    output logic                      o_din_ready,
    input  logic [7:0]                i_round,
    output logic                      o_clr_i,
    output logic                      o_cnt_i_en,
    output logic                      o_load_we,
    output logic [SHA512_WADDR_W-1:0] o_load_addr,
    output logic [63:0]               o_load_data,
    output logic                      o_init_h,
    output logic                      o_round_en,
    output logic                      o_update_h,
    output logic                      o_done,
`ifdef SHA512_CTRL_BLKCNT_EN
    output logic [15:0]               o_blk_cnt,
`endif
    output logic                      o_busy
);

    state_t state;
    state_t state_nxt;
    logic   block_full;
    logic   last_flag;
    logic   pack_en;

    assign pack_en = (state == ST_LOAD);
    assign o_busy  = (state != ST_IDLE);

    sha512_word_packer #(
        .BLK_WORDS (BLK_WORDS)
    ) u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .en         (pack_en),
        .din        (i_din),
        .din_valid  (i_din_valid),
        .last       (i_last),
        .din_ready  (o_din_ready),
        .load_we    (o_load_we),
        .load_addr  (o_load_addr),
        .load_data  (o_load_data),
        .block_full (block_full),
        .last_flag  (last_flag)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes; round strobes also depend on i_round.
    always_comb begin
        state_nxt  = state;
        o_clr_i    = 1'b0;
        o_cnt_i_en = 1'b0;
        o_init_h   = 1'b0;
        o_round_en = 1'b0;
        o_update_h = 1'b0;
        o_done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                o_init_h  = 1'b1;
                o_clr_i   = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (block_full) begin
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                o_round_en = 1'b1;
                if (i_round < 8'(ROUNDS - 1)) begin
                    o_cnt_i_en = 1'b1;
                end else begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                o_update_h = 1'b1;
                o_clr_i    = 1'b1;
                state_nxt  = last_flag ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef SHA512_CTRL_BLKCNT_EN
    // Blocks hashed in the current message; survives DONE/IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_blk_cnt <= 16'd0;
        end else if (state == ST_INIT) begin
            o_blk_cnt <= 16'd0;
        end else if (state == ST_UPDATE) begin
            o_blk_cnt <= o_blk_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha512_round_ctrl.sv
// Self-checking bench for sha512_round_ctrl with a model round counter.
// Write scoreboard plus table of block scenarios and hand-written corner cases.
module tb_sha512_round_ctrl;
    import sha512_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din = 32'd0;
    logic        din_valid = 1'b0;
    logic        last = 1'b0;
    logic [7:0]  rnd = 8'h55;

    logic        o_din_ready, o_clr_i, o_cnt_i_en, o_load_we;
    logic [3:0]  o_load_addr;
    logic [63:0] o_load_data;
    logic        o_init_h, o_round_en, o_update_h, o_done, o_busy;
`ifdef SHA512_CTRL_BLKCNT_EN
    logic [15:0] o_blk_cnt;
`endif

    sha512_round_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_din       (din),
        .i_din_valid (din_valid),
        .i_last      (last),
        .o_din_ready (o_din_ready),
        .i_round     (rnd),
        .o_clr_i     (o_clr_i),
        .o_cnt_i_en  (o_cnt_i_en),
        .o_load_we   (o_load_we),
        .o_load_addr (o_load_addr),
        .o_load_data (o_load_data),
        .o_init_h    (o_init_h),
        .o_round_en  (o_round_en),
        .o_update_h  (o_update_h),
        .o_done      (o_done),
`ifdef SHA512_CTRL_BLKCNT_EN
        .o_blk_cnt   (o_blk_cnt),
`endif
        .o_busy      (o_busy)
    );

    initial forever #5 clk = ~clk;

    // Model round counter: sync clear, increment, no reset of its own.
    always @(posedge clk) begin
        if (o_clr_i) rnd <= 8'd0;
        else if (o_cnt_i_en) rnd <= rnd + 8'd1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t sb[$];

    int   cyc = 0;
    int   n_we = 0, n_ren = 0, n_cen = 0, n_upd = 0, n_done = 0;
    logic prev_upd = 1'b0, prev_ren = 1'b0;
    bit   lat_arm = 0, lat_got0 = 0, lat_got1 = 0;
    int   lat_t0 = 0, lat_t1 = 0;

    initial forever begin
        wr_t e;
        @(negedge clk);
        cyc++;
        if (o_clr_i || o_cnt_i_en)
            check("clr_cnt_excl", 64'(o_clr_i & o_cnt_i_en), 64'd0);
        if (o_load_we) begin
            n_we++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(o_load_addr), 64'(e.addr));
                check("wr_data", o_load_data, e.data);
            end
        end
        if (o_round_en) begin
            n_ren++;
            if (!prev_ren) check("first_round_idx", 64'(rnd), 64'd0);
        end
        if (o_cnt_i_en) n_cen++;
        if (o_update_h) n_upd++;
        if (o_done) begin
            n_done++;
            check("done_after_update", 64'(prev_upd), 64'd1);
        end
        if (lat_arm && !lat_got0 && din_valid && o_din_ready) begin
            lat_t0 = cyc;
            lat_got0 = 1;
        end
        if (lat_arm && lat_got0 && !lat_got1 && o_round_en) begin
            lat_t1 = cyc;
            lat_got1 = 1;
        end
        prev_upd = o_update_h;
        prev_ren = o_round_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("init_clr", 64'(o_clr_i), 64'd1);
        check("init_h", 64'(o_init_h), 64'd1);
    endtask

    task automatic feed_block(input int blk, input logic lst, input bit gaps);
        logic [31:0] hi;
        int to;
        hi = 32'd0;
        for (int w = 0; w < SHA512_BLK_WORDS; w++) begin
            din = 32'(blk * SHA512_BLK_WORDS + w);
            din_valid = 1'b1;
            last = (w == SHA512_BLK_WORDS - 1) ? lst : 1'b0;
            to = 0;
            while (!o_din_ready && to < 300) begin
                tick();
                to++;
            end
            if (to >= 300) check("ready_timeout", 64'd1, 64'd0);
            if (w % 2 == 0) hi = din;
            else sb.push_back('{addr: 4'(w / 2), data: {hi, din}});
            tick();
            if (gaps) begin
                din_valid = 1'b0;
                last = 1'b0;
                tick();
            end
        end
        din_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_done();
        int to;
        to = 0;
        while (!o_done && to < 400) begin
            tick();
            to++;
        end
        check("done_seen", 64'(o_done), 64'd1);
    endtask

    function automatic logic [9:0] strobes();
        return {o_din_ready, o_clr_i, o_cnt_i_en, o_load_we, o_init_h,
                o_round_en, o_update_h, o_done, o_busy, |o_load_addr};
    endfunction

    typedef struct {
        int nblk;
        bit gaps;
        int exp_we;
        int exp_ren;
        int exp_cen;
        int exp_upd;
        int exp_lat;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int b_we, b_ren, b_cen, b_upd, b_done, to;

        vecs[0] = '{1, 0, 16, 80, 79, 1, 32};
        vecs[1] = '{2, 0, 32, 160, 158, 2, 32};
        vecs[2] = '{1, 1, 16, 80, 79, 1, 63};
        vecs[3] = '{3, 1, 48, 240, 237, 3, 63};

        rst = 1'b1;
        tick();
        tick();
        check("reset_strobes", 64'(strobes()), 64'd0);
        check("reset_data", o_load_data, 64'd0);
`ifdef SHA512_CTRL_BLKCNT_EN
        check("reset_blkcnt", 64'(o_blk_cnt), 64'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            b_we = n_we; b_ren = n_ren; b_cen = n_cen;
            b_upd = n_upd; b_done = n_done;
            lat_got0 = 0; lat_got1 = 0; lat_arm = 1;
            do_start();
            for (int b = 0; b < vecs[i].nblk; b++)
                feed_block(b, (b == vecs[i].nblk - 1), vecs[i].gaps);
            wait_done();
            start = 1'b1;
            tick();
            start = 1'b0;
            check("done_start_ignored", 64'(o_busy), 64'd0);
            check("done_one_cycle", 64'(o_done), 64'd0);
            lat_arm = 0;
            check("we_count", 64'(n_we - b_we), 64'(vecs[i].exp_we));
            check("round_en_count", 64'(n_ren - b_ren), 64'(vecs[i].exp_ren));
            check("cnt_en_count", 64'(n_cen - b_cen), 64'(vecs[i].exp_cen));
            check("update_count", 64'(n_upd - b_upd), 64'(vecs[i].exp_upd));
            check("done_count", 64'(n_done - b_done), 64'd1);
            check("load_to_round", 64'(lat_t1 - lat_t0), 64'(vecs[i].exp_lat));
            check("sb_empty", 64'(sb.size()), 64'd0);
`ifdef SHA512_CTRL_BLKCNT_EN
            check("blk_cnt", 64'(o_blk_cnt), 64'(vecs[i].nblk));
`endif
            tick();
        end

        // Reset in the middle of the round phase.
        b_upd = n_upd; b_done = n_done;
        do_start();
        feed_block(7, 1'b1, 0);
        to = 0;
        while (!(o_round_en && rnd == 8'd40) && to < 200) begin
            tick();
            to++;
        end
        check("reach_round40", 64'(rnd), 64'd40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_strobes", 64'(strobes()), 64'd0);
        check("midrst_data", o_load_data, 64'd0);
`ifdef SHA512_CTRL_BLKCNT_EN
        check("midrst_blkcnt", 64'(o_blk_cnt), 64'd0);
`endif
        for (int k = 0; k < 100; k++) tick();
        check("midrst_no_done", 64'(n_done - b_done), 64'd0);
        check("midrst_no_update", 64'(n_upd - b_upd), 64'd0);
        b_ren = n_ren; b_done = n_done;
        do_start();
        feed_block(8, 1'b1, 0);
        wait_done();
        tick();
        check("restart_rounds", 64'(n_ren - b_ren), 64'd80);
        check("restart_done", 64'(n_done - b_done), 64'd1);
        check("restart_sb_empty", 64'(sb.size()), 64'd0);

        // Start and valid held during ROUND/UPDATE must be ignored.
        b_we = n_we; b_ren = n_ren; b_done = n_done;
        do_start();
        feed_block(5, 1'b1, 0);
        to = 0;
        while (!o_round_en && to < 100) begin
            tick();
            to++;
        end
        check("reach_round", 64'(o_round_en), 64'd1);
        to = 0;
        start = 1'b1;
        din_valid = 1'b1;
        din = 32'hDEADBEEF;
        while (to < 200) begin
            check("ignored_ready", 64'(o_din_ready), 64'd0);
            if (o_update_h) break;
            tick();
            to++;
        end
        start = 1'b0;
        din_valid = 1'b0;
        wait_done();
        tick();
        check("ignored_we", 64'(n_we - b_we), 64'd16);
        check("ignored_rounds", 64'(n_ren - b_ren), 64'd80);
        check("ignored_done", 64'(n_done - b_done), 64'd1);
        check("ignored_idle", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
